ads1675_rx: RTL and testbench

- Source-synchronous receiver for the ADS1675 serial output. Sits directly downstream of the ADC pins, after differential input buffering.
- Runs on the forwarded ADC bit clock.
- Detects each DRDY frame start, deserializes the MSB-first 24-bit two's-complement sample from DOUT, and presents it on a valid/ready output with overrun, framing and timeout supervision.
- Feeds the DAQ sample FIFO.

---
 rtl/ads1675_rx.sv | 145 ++++++++++++++
 tb/tb_ads1675_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1675_rx.sv
// ADS1675 serial receiver: DRDY-framed MSB-first deserializer with a registered
// valid/ready output and overrun, framing and timeout supervision.
module ads1675_rx #(
  parameter int unsigned DW      = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          drdy,
  input  logic          dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          clr_err,
  output logic          frame_err,
  output logic          timeout_err,
  output logic          overrun,
  output logic [7:0]    overrun_cnt
);

  localparam int unsigned BCW = $clog2(DW);
  localparam int unsigned GCW = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e          state_q;
  logic [BCW-1:0]  bitcnt_q;
  logic [DW-2:0]   shift_q;
  logic            drdy_q;
  logic            armed_q;
  logic [GCW-1:0]  gapcnt_q;
  logic [DW-1:0]   m_data_q;
  logic            m_valid_q;
  logic            frame_err_q;
  logic            timeout_err_q;
  logic            overrun_q;
  logic [7:0]      overrun_cnt_q;

  logic            rise_c;
  logic            last_c;
  logic            done_c;
  logic            fe_c;
  logic            to_c;
  logic            ovr_c;
  logic [DW-1:0]   word_c;

  // Frame-edge detection and per-edge events feeding the registers below.
  assign rise_c = en & drdy & ~drdy_q;
  assign last_c = (state_q == ST_SHIFT) && (bitcnt_q == BCW'(DW - 1));
  assign done_c = en & last_c;
  assign fe_c   = rise_c & (state_q == ST_SHIFT) & ~last_c;
  assign to_c   = en & armed_q & ~rise_c & (gapcnt_q == GCW'(TIMEOUT - 1));
  assign ovr_c  = done_c & m_valid_q & ~m_ready;
  assign word_c = {shift_q, dout};

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      drdy_q        <= 1'b0;
      armed_q       <= 1'b0;
      gapcnt_q      <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      drdy_q <= drdy;

      // Deserializer: a rise inside a frame restarts it with this edge as the MSB.
      if (!en) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise_c) begin
              shift_q  <= (DW-1)'(dout);
              bitcnt_q <= BCW'(1);
              state_q  <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (last_c) begin
              bitcnt_q <= '0;
              state_q  <= ST_IDLE;
            end else if (rise_c) begin
              shift_q  <= (DW-1)'(dout);
              bitcnt_q <= BCW'(1);
            end else begin
              shift_q  <= word_c[DW-2:0];
              bitcnt_q <= bitcnt_q + BCW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      // Watchdog armed by the first rise; gap counter saturates at TIMEOUT.
      if (!en) begin
        armed_q  <= 1'b0;
        gapcnt_q <= '0;
      end else if (rise_c) begin
        armed_q  <= 1'b1;
        gapcnt_q <= '0;
      end else if (armed_q && (gapcnt_q != GCW'(TIMEOUT))) begin
        gapcnt_q <= gapcnt_q + GCW'(1);
      end

      if (done_c) begin
        m_data_q  <= word_c;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      // Clear wins over any same-edge set.
      if (clr_err) begin
        frame_err_q   <= 1'b0;
        timeout_err_q <= 1'b0;
        overrun_q     <= 1'b0;
        overrun_cnt_q <= '0;
      end else begin
        if (fe_c) frame_err_q   <= 1'b1;
        if (to_c) timeout_err_q <= 1'b1;
        if (ovr_c) begin
          overrun_q <= 1'b1;
          if (overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
        end
      end
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_ads1675_rx.sv
// Bench for ads1675_rx: directed scenarios plus randomized frames checked
// against a behavioural frame model.
module tb_ads1675_rx;

  localparam int DW      = 24;
  localparam int TIMEOUT = 64;

  logic          sclk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          drdy;
  logic          dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          clr_err;
  logic          frame_err;
  logic          timeout_err;
  logic          overrun;
  logic [7:0]    overrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  ads1675_rx #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .sclk(sclk), .rst_n(rst_n), .en(en), .drdy(drdy), .dout(dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clr_err(clr_err),
    .frame_err(frame_err), .timeout_err(timeout_err), .overrun(overrun),
    .overrun_cnt(overrun_cnt)
  );

  always #5 sclk = ~sclk;

  // Behavioural model: counts bits received since the last frame start.
  int            m_bits;
  int            m_acc;
  logic          m_prev;
  logic          m_armed;
  int            m_gap;
  logic [DW-1:0] e_data;
  logic          e_valid, e_fe, e_to, e_ovr;
  int            e_cnt;

  always @(posedge sclk or negedge rst_n) begin : model
    bit r, dn, fe, to, ov;
    if (!rst_n) begin
      m_bits = 0; m_acc = 0; m_prev = 1'b0; m_armed = 1'b0; m_gap = 0;
      e_data = '0; e_valid = 1'b0; e_fe = 1'b0; e_to = 1'b0; e_ovr = 1'b0; e_cnt = 0;
    end else begin
      r = en && drdy && !m_prev;
      m_prev = drdy;
      dn = 0; fe = 0; to = 0; ov = 0;
      if (!en) begin
        m_bits = 0; m_armed = 1'b0; m_gap = 0;
      end else begin
        if (m_bits == 0) begin
          if (r) begin m_acc = int'(dout); m_bits = 1; end
        end else if (m_bits == DW - 1) begin
          m_acc = m_acc * 2 + int'(dout); dn = 1; m_bits = 0;
        end else if (r) begin
          fe = 1; m_acc = int'(dout); m_bits = 1;
        end else begin
          m_acc = m_acc * 2 + int'(dout); m_bits++;
        end
        if (r) begin
          m_armed = 1'b1; m_gap = 0;
        end else if (m_armed && m_gap < TIMEOUT) begin
          m_gap++;
          if (m_gap == TIMEOUT) to = 1;
        end
      end
      if (dn) begin
        ov = e_valid && !m_ready;
        e_data = DW'(m_acc);
        e_valid = 1'b1;
      end else if (e_valid && m_ready) begin
        e_valid = 1'b0;
      end
      if (clr_err) begin
        e_fe = 1'b0; e_to = 1'b0; e_ovr = 1'b0; e_cnt = 0;
      end else begin
        if (fe) e_fe = 1'b1;
        if (to) e_to = 1'b1;
        if (ov) begin e_ovr = 1'b1; if (e_cnt < 255) e_cnt++; end
      end
    end
  end

  function automatic logic bitof(input logic [DW-1:0] w, input int i);
    if (i < DW) return w[DW-1-i];
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive the values captured at the next rising edge.
  task automatic step(input logic d, input logic o);
    @(negedge sclk);
    drdy = d;
    dout = o;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; drdy = 1'b0; dout = 1'b0; m_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (m_data !== '0) $display("FAIL reset_data: got %h want 0", m_data); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if ({frame_err, timeout_err, overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {frame_err, timeout_err, overrun}); else n_pass++;
    n_checks++; if (overrun_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", overrun_cnt); else n_pass++;
  endtask

  task automatic test_nominal();
    logic [DW-1:0] w;
    apply_reset(); en = 1'b1; m_ready = 1'b1;
    w = 24'h800001;
    for (int i = 0; i < 48; i++) begin
      step(i < 4, bitof(w, i));
      if (i == 23) begin
        n_checks++; if (m_valid !== 1'b0) $display("FAIL nom_valid_early: got %b want 0", m_valid); else n_pass++;
      end
      if (i == 24) begin
        n_checks++; if (m_valid !== 1'b1) $display("FAIL nom_valid: got %b want 1", m_valid); else n_pass++;
        n_checks++; if ($signed(m_data) !== -24'sd8388607)
          $display("FAIL nom_data: got %h want 800001", m_data); else n_pass++;
      end
      if (i == 25) begin
        n_checks++; if (m_valid !== 1'b0) $display("FAIL nom_accept: got %b want 0", m_valid); else n_pass++;
      end
    end
    w = 24'h7FFFFF;
    for (int i = 0; i < 48; i++) begin
      step(i < 4, bitof(w, i));
      if (i == 24) begin
        n_checks++; if (m_data !== 24'h7FFFFF) $display("FAIL nom_data2: got %h want 7fffff", m_data); else n_pass++;
      end
    end
    n_checks++; if ({frame_err, timeout_err, overrun} !== 3'b000)
      $display("FAIL nom_flags: got %b want 000", {frame_err, timeout_err, overrun}); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w;
    apply_reset(); en = 1'b1; m_ready = 1'b0;
    w = 24'h000010;
    for (int i = 0; i < 48; i++) step(i < 4, bitof(w, i));
    n_checks++; if ({m_valid, overrun} !== 2'b10)
      $display("FAIL bp_first: got valid/ovr %b want 10", {m_valid, overrun}); else n_pass++;
    w = 24'h000020;
    for (int i = 0; i < 48; i++) begin
      step(i < 4, bitof(w, i));
      if (i == 24) begin
        n_checks++; if (m_data !== 24'h000020) $display("FAIL bp_data: got %h want 000020", m_data); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else n_pass++;
        n_checks++; if (overrun_cnt !== 8'd1) $display("FAIL bp_cnt: got %0d want 1", overrun_cnt); else n_pass++;
        m_ready = 1'b1;
      end
      if (i == 25) begin
        n_checks++; if (m_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_data !== 24'h000020) $display("FAIL bp_hold: got %h want 000020", m_data); else n_pass++;
        m_ready = 1'b0;
      end
    end
  endtask

  task automatic test_early_drdy();
    logic [DW-1:0] wa, wb;
    apply_reset(); en = 1'b1; m_ready = 1'b0;
    wa = 24'($urandom); wb = 24'($urandom);
    for (int i = 0; i < 10; i++) step(i < 4, bitof(wa, i));
    for (int i = 0; i < 48; i++) begin
      step(i < 4, bitof(wb, i));
      if (i == 0) begin
        n_checks++; if (frame_err !== 1'b0) $display("FAIL early_fe_pre: got %b want 0", frame_err); else n_pass++;
      end
      if (i == 1) begin
        n_checks++; if (frame_err !== 1'b1) $display("FAIL early_fe: got %b want 1", frame_err); else n_pass++;
      end
      if (i == 23) begin
        n_checks++; if (m_valid !== 1'b0) $display("FAIL early_valid_pre: got %b want 0", m_valid); else n_pass++;
      end
      if (i == 24) begin
        n_checks++; if ({m_valid, m_data} !== {1'b1, wb})
          $display("FAIL early_data: got %b/%h want 1/%h", m_valid, m_data, wb); else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] w;
    apply_reset(); en = 1'b1; m_ready = 1'b1;
    w = 24'($urandom);
    for (int i = 0; i < 80; i++) begin
      step(i < 4, bitof(w, i));
      if (i == 64) begin
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_early: got %b want 0", timeout_err); else n_pass++;
      end
      if (i == 65) begin
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_set: got %b want 1", timeout_err); else n_pass++;
      end
      if (i == 70) clr_err = 1'b1;
      if (i == 71) clr_err = 1'b0;
      if (i == 72) begin
        n_checks++; if ({frame_err, timeout_err, overrun, overrun_cnt} !== 11'd0)
          $display("FAIL to_clear: got %b want 0", {frame_err, timeout_err, overrun, overrun_cnt}); else n_pass++;
      end
    end
  endtask

  task automatic test_en_drop();
    logic [DW-1:0] w1, w2;
    apply_reset(); en = 1'b1; m_ready = 1'b1;
    w1 = 24'($urandom); w2 = 24'($urandom);
    for (int i = 0; i < 12; i++) step(i < 4, bitof(w1, i));
    @(negedge sclk); en = 1'b0; drdy = 1'b0; dout = bitof(w1, 12);
    for (int j = 0; j < 90; j++) begin
      step((j % 48) < 4, 1'($urandom_range(0, 1)));
      n_checks++; if (m_valid !== 1'b0) $display("FAIL en_valid: got %b want 0 at %0d", m_valid, j); else n_pass++;
    end
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL en_timeout: got %b want 0", timeout_err); else n_pass++;
    en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step(i < 4, bitof(w2, i));
      if (i == 24) begin
        n_checks++; if ({m_valid, m_data} !== {1'b1, w2})
          $display("FAIL en_data: got %b/%h want 1/%h", m_valid, m_data, w2); else n_pass++;
      end
    end
    n_checks++; if ({frame_err, timeout_err} !== 2'b00)
      $display("FAIL en_flags: got %b want 00", {frame_err, timeout_err}); else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [DW-1:0] w1, w2, w3;
    apply_reset(); en = 1'b1; m_ready = 1'b0;
    w1 = 24'($urandom) | 24'h1; w2 = 24'($urandom); w3 = 24'($urandom);
    for (int i = 0; i < 48; i++) step(i < 4, bitof(w1, i));
    n_checks++; if (m_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", m_valid); else n_pass++;
    for (int i = 0; i < 10; i++) step(i < 4, bitof(w2, i));
    @(negedge sclk); rst_n = 1'b0; drdy = 1'b0; dout = 1'b0;
    #1;
    n_checks++; if ({m_data, m_valid, frame_err, timeout_err, overrun, overrun_cnt} !== 36'h0)
      $display("FAIL rst_async: got %h want 0", {m_data, m_valid, frame_err, timeout_err, overrun, overrun_cnt});
    else n_pass++;
    @(negedge sclk); rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    for (int i = 0; i < 48; i++) begin
      step(i < 4, bitof(w3, i));
      if (i == 24) begin
        n_checks++; if ({m_valid, m_data} !== {1'b1, w3})
          $display("FAIL rst_data: got %b/%h want 1/%h", m_valid, m_data, w3); else n_pass++;
      end
    end
    n_checks++; if ({frame_err, overrun} !== 2'b00)
      $display("FAIL rst_flags: got %b want 00", {frame_err, overrun}); else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    int len;
    apply_reset(); en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      w = 24'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 22) : $urandom_range(24, 72);
      for (int i = 0; i < len; i++) begin
        step(i < 4, bitof(w, i));
        n_checks++;
        if ({m_data, m_valid, frame_err, timeout_err, overrun, overrun_cnt} !==
            {e_data, e_valid, e_fe, e_to, e_ovr, 8'(e_cnt)})
          $display("FAIL rand_f%0d_b%0d: got %h want %h", f, i,
                   {m_data, m_valid, frame_err, timeout_err, overrun, overrun_cnt},
                   {e_data, e_valid, e_fe, e_to, e_ovr, 8'(e_cnt)});
        else n_pass++;
        m_ready = 1'($urandom_range(0, 1));
        clr_err = ($urandom_range(0, 40) == 0);
      end
    end
    clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_drdy();
    test_timeout();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
